ai_task_arbiter: RTL

//   Shares one accelerator task port among N_REQ requesting cores.

---
 rtl/ai_task_arbiter_if.sv | 32 +++
 rtl/ai_task_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ai_task_arbiter_if.sv
// Task bus between the requesting cores / accelerator and the arbiter.
// slave  : the arbiter's view (takes core requests and accelerator status, drives grants and the task).
// master : the surrounding system's view (cores plus accelerator), the mirror of slave.
interface ai_task_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 8,
  parameter int TYPE_W = 8
);
  // Core side: slot i of the packed id/type vectors lives at [i*W +: W].
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ID_W-1:0]   req_id;
  logic [N_REQ*TYPE_W-1:0] req_type;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_done;
  logic [N_REQ-1:0]        req_error;
  // Accelerator side.
  logic                    acc_task_valid;
  logic [ID_W-1:0]         acc_task_id;
  logic [TYPE_W-1:0]       acc_task_type;
  logic                    acc_task_ready;
  logic                    acc_task_done;

  modport slave (
    input  req_valid, req_id, req_type, acc_task_ready, acc_task_done,
    output req_ready, req_done, req_error, acc_task_valid, acc_task_id, acc_task_type
  );

  modport master (
    output req_valid, req_id, req_type, acc_task_ready, acc_task_done,
    input  req_ready, req_done, req_error, acc_task_valid, acc_task_id, acc_task_type
  );
endinterface

// File: rtl/ai_task_arbiter.sv
// Purpose: round-robin share of one accelerator task port among N_REQ cores, one task in flight.
// Latency: grant -> acc_task_valid 1 cycle; acc_task_done (or timeout) -> req_done/req_error 1 cycle.
// Backpressure: req_ready only while idle; task held stable in ISSUE until acc_task_ready.
// Ports: clk/rst (sync, active-high); bus = ai_task_arbiter_if.slave (core requests, grants,
//        done/error pulses, accelerator task handshake); busy = task in flight; owner = current/last owner.
module ai_task_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 8,
  parameter int TYPE_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  ai_task_arbiter_if.slave         bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int OWN_W = $clog2(N_REQ);
  // Last counter value a task may reach before it is declared lost.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   error_q, error_d;

  logic               grant_vld;
  logic [OWN_W-1:0]   grant_idx;
  logic               timeout_hit;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = OWN_W'(idx);
      end
    end
  end

  // Grant strobe is combinational so a core sees acceptance in the cycle it asks.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_vld) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    id_d     = id_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    error_d  = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = ISSUE;
          rr_ptr_d = grant_idx;
          owner_d  = grant_idx;
          id_d     = bus.req_id[int'(grant_idx)*ID_W +: ID_W];
          type_d   = bus.req_type[int'(grant_idx)*TYPE_W +: TYPE_W];
          cnt_d    = '0;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        // A stalled issue is abandoned at the limit even if ready arrives that same cycle.
        if (timeout_hit) begin
          state_d          = IDLE;
          error_d[owner_q] = 1'b1;
        end else if (bus.acc_task_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // Completion beats a coincident timeout.
        if (bus.acc_task_done) begin
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
        end else if (timeout_hit) begin
          state_d          = IDLE;
          error_d[owner_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= OWN_W'(N_REQ - 1);
      owner_q  <= '0;
      id_q     <= '0;
      type_q   <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      error_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      id_q     <= id_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.acc_task_valid = (state_q == ISSUE);
  assign bus.acc_task_id    = id_q;
  assign bus.acc_task_type  = type_q;
  assign bus.req_done       = done_q;
  assign bus.req_error      = error_q;
  assign busy               = (state_q != IDLE);
  assign owner              = owner_q;

endmodule
